// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_pkg
//  Description : Shared definitions for the 4-bit adder and its sequential
//                accumulate controller: default widths and FSM encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package adder_pkg;

    // Default operand/sum width; must match the combinational adder.
    localparam int ADDER_WIDTH = 4;

    // Default width of the operand count and the carry counter.
    localparam int ADDER_CNT_W = 4;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } acc_state_e;

endpackage : adder_pkg
`default_nettype wire

// File: rtl/adder_accum_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : adder_accum_ctrl
//  Description : Sequential front/back end around a combinational adder.
//                Streams a burst of operands into the adder, folds each
//                sum/cout back into an accumulator and carry count, then
//                offers the final result on a valid/ready output.
//  Revision    : 1.0  initial release
// ============================================================================
module adder_accum_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int CNT_W = ADDER_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_ops,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_carries,
    output logic             busy
);

    acc_state_e       state_q,    state_d;
    logic [WIDTH-1:0] acc_q,      acc_d;
    logic [CNT_W-1:0] carries_q,  carries_d;
    logic [CNT_W-1:0] ops_left_q, ops_left_d;

    // Carry-out widened to the counter width so the increment is width-exact.
    logic [CNT_W-1:0] cout_ext;
    assign cout_ext = {{(CNT_W-1){1'b0}}, add_cout};

    // State and datapath registers; reset discards any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            carries_q  <= '0;
            ops_left_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            carries_q  <= carries_d;
            ops_left_q <= ops_left_d;
        end
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        carries_d  = carries_q;
        ops_left_d = ops_left_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d      = '0;
                    carries_d  = '0;
                    ops_left_d = num_ops;
                    // An empty burst goes straight to a zero result.
                    state_d    = (num_ops == '0) ? ST_DONE : ST_LOAD;
                end
            end

            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d      = add_sum;
                    carries_d  = carries_q + cout_ext;
                    ops_left_d = ops_left_q - 1'b1;
                    if (ops_left_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The adder always sees the running accumulator and the live operand.
    assign add_a       = acc_q;
    assign add_b       = in_data;
    assign out_sum     = acc_q;
    assign out_carries = carries_q;
    assign busy        = (state_q != ST_IDLE);

endmodule : adder_accum_ctrl
`default_nettype wire

// File: tb/tb_adder_accum_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_accum_ctrl
//  Description : Bench for adder_accum_ctrl with a behavioural 4-bit adder
//                closing the loop and a burst-level result model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adder_accum_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_ops = '0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic [CNT_W-1:0] out_carries;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_hs  = 0;

    // Expected results per burst, packed {sum, carries}.
    logic [7:0] exp_q [$];
    logic [3:0] ops [16];

    always #5 clk = ~clk;

    // The combinational adder the controller sits around.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    adder_accum_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_ops     (num_ops),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_sum     (add_sum),
        .add_cout    (add_cout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_carries (out_carries),
        .busy        (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle result checker against the model queue.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("model_sum", int'(out_sum), int'(exp_q[0][7:4]));
                check("model_carries", int'(out_carries), int'(exp_q[0][3:0]));
                if (out_ready) begin
                    n_hs++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Burst-level model: plain integer sum, carries counted per step.
    task automatic model_push(input int n);
        int acc;
        int c;
        int s;
        acc = 0;
        c   = 0;
        for (int i = 0; i < n; i++) begin
            s   = acc + int'(ops[i]);
            c   = c + (s / 16);
            acc = s % 16;
        end
        exp_q.push_back({4'(acc), 4'(c)});
    endtask

    // Drive one burst; gaps inserts idle cycles between operands and
    // hold keeps out_ready low for that many cycles once the result is up.
    task automatic run_burst(input int n, input bit gaps, input int hold,
                             output logic [3:0] s, output logic [3:0] c);
        int guard;
        model_push(n);
        out_ready = (hold == 0);
        @(posedge clk); #1;
        start   = 1'b1;
        num_ops = 4'(n);
        @(posedge clk); #1;
        start   = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 2 == 1)) begin
                in_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = ops[i];
            guard    = 0;
            @(negedge clk);
            while (!in_ready && guard < 20) begin
                guard++;
                @(negedge clk);
            end
            if (guard >= 20) check("in_ready_timeout", 0, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        // Result must be up right after the last acceptance edge.
        check("latency_out_valid", int'(out_valid), 1);
        s = out_sum;
        c = out_carries;
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_sum", int'(out_sum), int'(s));
            check("hold_carries", int'(out_carries), int'(c));
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("back_to_idle_busy", int'(busy), 0);
        check("back_to_idle_valid", int'(out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] s;
        logic [3:0] c;
        int hs0;

        // Reset state
        #12;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out_sum", int'(out_sum), 0);
        check("rst_add_a", int'(add_a), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // in_valid in IDLE is ignored
        in_valid = 1'b1;
        in_data  = 4'd7;
        repeat (2) @(posedge clk);
        #1;
        check("idle_ignores_valid", int'(busy), 0);
        in_valid = 1'b0;

        // 1: 1010 + 0101
        ops[0] = 4'b1010; ops[1] = 4'b0101;
        run_burst(2, 1'b0, 0, s, c);
        check("t1_sum", int'(s), 15);
        check("t1_carries", int'(c), 0);

        // 2: 1111 + 1111
        ops[0] = 4'b1111; ops[1] = 4'b1111;
        run_burst(2, 1'b0, 0, s, c);
        check("t2_sum", int'(s), 14);
        check("t2_carries", int'(c), 1);

        // 3: fifteen operands of 1111
        for (int i = 0; i < 15; i++) ops[i] = 4'b1111;
        run_burst(15, 1'b0, 0, s, c);
        check("t3_sum", int'(s), 1);
        check("t3_carries", int'(c), 14);

        // 4: empty burst
        run_burst(0, 1'b0, 0, s, c);
        check("t4_sum", int'(s), 0);
        check("t4_carries", int'(c), 0);

        // 5: backpressure on both sides
        ops[0] = 4'd9; ops[1] = 4'd8; ops[2] = 4'd12; ops[3] = 4'd3;
        hs0 = n_hs;
        run_burst(4, 1'b1, 5, s, c);
        check("t5_sum", int'(s), 0);
        check("t5_carries", int'(c), 2);
        check("t5_one_handshake", n_hs - hs0, 1);

        // 6: reset after one of three operands
        out_ready = 1'b1;
        @(posedge clk); #1;
        start   = 1'b1;
        num_ops = 4'd3;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t6_midburst_busy", int'(busy), 1);
        check("t6_midburst_acc", int'(add_a), 6);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_in_ready", int'(in_ready), 0);
        check("t6_rst_out_valid", int'(out_valid), 0);
        check("t6_rst_sum", int'(out_sum), 0);
        check("t6_rst_carries", int'(out_carries), 0);
        check("t6_rst_add_a", int'(add_a), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ops[0] = 4'b0011; ops[1] = 4'b0001;
        run_burst(2, 1'b0, 0, s, c);
        check("t6_sum", int'(s), 4);
        check("t6_carries", int'(c), 0);

        check("model_queue_drained", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_adder_accum_ctrl
`default_nettype wire
